// File: rtl/card_rom_pkg.sv
// rtl/card_rom_pkg.sv - shared widths and card select encoding for the card ROM arbiter
//
// Purpose: common widths of the card image ROM interface, the default burst
//          length and the card_id encoding (suit * 13 + rank, plus special
//          sprites above the 52 playing cards).
// Ports:   none (package).
package card_rom_pkg;

   localparam int ADDR_W            = 12;   // {y[5:0], x[5:0]}
   localparam int RGB_W             = 12;   // 4:4:4 RGB
   localparam int CARD_W            = 6;    // card select into the ROM bank
   localparam int DEFAULT_BURST_LEN = 48;   // one card sprite line

   localparam int NUM_RANKS = 13;
   localparam int NUM_CARDS = 52;

   typedef enum logic [1:0] {
      SUIT_CLUBS    = 2'd0,
      SUIT_DIAMONDS = 2'd1,
      SUIT_HEARTS   = 2'd2,
      SUIT_SPADES   = 2'd3
   } suit_e;

   // Sprites stored after the 52 faces.
   localparam logic [CARD_W-1:0] CARD_BACK  = 6'd52;
   localparam logic [CARD_W-1:0] CARD_BLANK = 6'd53;

   // rank is 0 (ace) .. 12 (king)
   function automatic logic [CARD_W-1:0] card_index(input suit_e suit, input logic [3:0] rank);
      return CARD_W'(suit) * CARD_W'(NUM_RANKS) + CARD_W'(rank);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner selection
//
// Purpose: picks the first asserted request at or after ptr, scanning upward
//          with wrap-around. Purely combinational.
// Ports:
//   req    in   NUM_REQ  request vector
//   ptr    in   IDX_W    priority pointer (0..NUM_REQ-1)
//   gnt    out  NUM_REQ  one-hot grant (zero when no request)
//   winner out  IDX_W    index of the granted requester
//   valid  out  1        some requester was granted
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   int scan_idx;

   always_comb begin
      gnt      = '0;
      winner   = '0;
      valid    = 1'b0;
      scan_idx = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         scan_idx = int'(ptr) + off;
         if (scan_idx >= NUM_REQ) begin
            scan_idx = scan_idx - NUM_REQ;
         end
         // First hit wins; later hits are ignored once valid is set.
         if (!valid && req[scan_idx]) begin
            gnt[scan_idx] = 1'b1;
            winner        = IDX_W'(scan_idx);
            valid         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/card_rom_arbiter.sv
// rtl/card_rom_arbiter.sv - round-robin sharing of the card image ROM among sprite drawers
//
// Purpose: accepts at most one ROM read per cycle, registers the address and
//          card select toward the ROM, and returns the ROM pixel two cycles
//          later tagged with a one-hot valid for the requester that issued it.
// Configuration macro: ARB_BURST_EN - when defined, the current owner keeps the
//          grant for up to BURST_LEN consecutive accepts; otherwise strict
//          per-cycle round-robin with no burst counter.
// Ports:
//   clk        in   1              pixel clock
//   rst_n      in   1              asynchronous active-low reset
//   req        in   NUM_REQ        read request, held until granted
//   addr       in   NUM_REQ x 12   pixel address {y, x}
//   card_id    in   NUM_REQ x 6    card select
//   gnt        out  NUM_REQ        one-hot combinational grant
//   rom_addr   out  12             registered ROM address
//   rom_card   out  6              registered ROM card select
//   rom_rgb    in   12             ROM data, one cycle after rom_addr
//   rgb        out  12             returned pixel (zero when not valid)
//   rgb_valid  out  NUM_REQ        one-hot owner of rgb
module card_rom_arbiter
   import card_rom_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int BURST_LEN = DEFAULT_BURST_LEN
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr,
   input  logic [NUM_REQ-1:0][CARD_W-1:0]   card_id,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [ADDR_W-1:0]                rom_addr,
   output logic [CARD_W-1:0]                rom_card,
   input  logic [RGB_W-1:0]                 rom_rgb,
   output logic [RGB_W-1:0]                 rgb,
   output logic [NUM_REQ-1:0]               rgb_valid
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic [CARD_W-1:0]  rom_card_q, rom_card_d;
   logic [NUM_REQ-1:0] tag1_q, tag1_d;
   logic [NUM_REQ-1:0] tag2_q, tag2_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_valid;
   logic [IDX_W-1:0]   idx_inc;

`ifdef ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_eff;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req    (req),
      .ptr    (ptr_q),
      .gnt    (arb_gnt),
      .winner (arb_idx),
      .valid  (arb_valid)
   );

   // Grant is held off while in reset so no drawer sees an accept.
   assign gnt = rst_n ? arb_gnt : '0;

   assign idx_inc = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);

   always_comb begin
      ptr_d      = ptr_q;
      rom_addr_d = rom_addr_q;
      rom_card_d = rom_card_q;
      tag1_d     = '0;
      tag2_d     = tag1_q;
`ifdef ARB_BURST_EN
      cnt_d      = '0;
      // The count only carries over when the pointer's owner wins again;
      // anyone else winning means the previous owner let go, so a new run starts.
      cnt_eff    = (arb_idx == ptr_q) ? cnt_q : '0;
`endif
      if (arb_valid) begin
         rom_addr_d = addr[arb_idx];
         rom_card_d = card_id[arb_idx];
         tag1_d     = arb_gnt;
`ifdef ARB_BURST_EN
         if (cnt_eff == CNT_W'(BURST_LEN - 1)) begin
            ptr_d = idx_inc;
            cnt_d = '0;
         end else begin
            // Pointer parks on the owner so it keeps priority next cycle.
            ptr_d = arb_idx;
            cnt_d = cnt_eff + CNT_W'(1);
         end
`else
         ptr_d = idx_inc;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         rom_addr_q <= '0;
         rom_card_q <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
`ifdef ARB_BURST_EN
         cnt_q      <= '0;
`endif
      end else begin
         ptr_q      <= ptr_d;
         rom_addr_q <= rom_addr_d;
         rom_card_q <= rom_card_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag2_d;
`ifdef ARB_BURST_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign rom_addr  = rom_addr_q;
   assign rom_card  = rom_card_q;
   assign rgb_valid = tag2_q;
   // Stage 2 lines up with the ROM output register, so rom_rgb belongs to the tag owner.
   assign rgb       = (|tag2_q) ? rom_rgb : '0;

endmodule

// File: tb/tb_card_rom_arbiter.sv
// tb/tb_card_rom_arbiter.sv - self-checking bench for card_rom_arbiter with a scoreboard model
module tb_card_rom_arbiter;

   localparam int N  = 3;
   localparam int BL = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic [N-1:0]        req;
   logic [N-1:0][11:0]  addr;
   logic [N-1:0][5:0]   card_id;
   logic [N-1:0]        gnt;
   logic [11:0]         rom_addr;
   logic [5:0]          rom_card;
   logic [11:0]         rom_rgb = 12'h000;
   logic [11:0]         rgb;
   logic [N-1:0]        rgb_valid;

   int errors = 0;
   int checks = 0;

   card_rom_arbiter #(.NUM_REQ(N), .BURST_LEN(BL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .addr      (addr),
      .card_id   (card_id),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_card  (rom_card),
      .rom_rgb   (rom_rgb),
      .rgb       (rgb),
      .rgb_valid (rgb_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_f(input logic [5:0] c, input logic [11:0] a);
      return a ^ {c, 6'h00};
   endfunction

   // Card ROM: one-cycle registered read.
   always @(posedge clk) rom_rgb <= rom_f(rom_card, rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      int          due;
      int          k;
      logic [11:0] a;
      logic [5:0]  c;
   } rd_t;

   rd_t         q[$];
   int          cyc        = 0;
   int          m_ptr      = 0;   // requester with first priority
   int          m_own      = -1;  // requester of the current run of accepts
   int          m_run      = 0;   // accepts in the current run
   logic [11:0] m_rom_addr = 12'h000;
   logic [5:0]  m_rom_card = 6'h00;

   function automatic int scan(input logic [N-1:0] r, input int p);
      for (int o = 0; o < N; o++) begin
         if (r[(p + o) % N]) return (p + o) % N;
      end
      return -1;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         q.delete();
         m_ptr = 0; m_own = -1; m_run = 0;
         m_rom_addr = 12'h000; m_rom_card = 6'h00;
      end else begin
         int mk;
         rd_t e;
         mk = scan(req, m_ptr);
         if (mk >= 0) begin
            e.due = cyc + 2; e.k = mk; e.a = addr[mk]; e.c = card_id[mk];
            q.push_back(e);
            m_rom_addr = addr[mk];
            m_rom_card = card_id[mk];
`ifdef ARB_BURST_EN
            if (mk == m_own) m_run++;
            else begin m_own = mk; m_run = 1; end
            if (m_run == BL) begin
               m_ptr = (mk + 1) % N; m_own = -1; m_run = 0;
            end else begin
               m_ptr = mk;
            end
`else
            m_ptr = (mk + 1) % N;
`endif
         end else begin
            m_own = -1; m_run = 0;
         end
         cyc++;
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      int          k;
      logic [N-1:0] eg, ev;
      logic [11:0]  er;
      @(negedge clk);
      k  = scan(req, m_ptr);
      eg = '0;
      if (rst_n && k >= 0) eg[k] = 1'b1;
      ev = '0;
      er = 12'h000;
      if (rst_n && q.size() > 0 && q[0].due == cyc) begin
         ev[q[0].k] = 1'b1;
         er = rom_f(q[0].c, q[0].a);
         void'(q.pop_front());
      end
      chk("gnt",       32'(gnt),       32'(eg));
      chk("rom_addr",  32'(rom_addr),  32'(m_rom_addr));
      chk("rom_card",  32'(rom_card),  32'(m_rom_card));
      chk("rgb_valid", 32'(rgb_valid), 32'(ev));
      chk("rgb",       32'(rgb),       32'(er));
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [N-1:0] pat [10];

   initial begin
      req     = '0;
      addr    = '0;
      card_id = '0;
`ifdef ARB_BURST_EN
      pat = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001};
`else
      pat = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
      #1 rst_n = 1'b0;
      req = 3'b111;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_gnt",       32'(gnt),       32'h0);
      chk("reset_rom_addr",  32'(rom_addr),  32'h0);
      chk("reset_rom_card",  32'(rom_card),  32'h0);
      chk("reset_rgb_valid", 32'(rgb_valid), 32'h0);
      chk("reset_rgb",       32'(rgb),       32'h0);
      req   = '0;
      rst_n = 1'b1;

      // Single request
      req = 3'b001; addr[0] = 12'h041; card_id[0] = 6'd5;
      @(negedge clk); chk("single_gnt", 32'(gnt), 32'h1);
      tick(); req = '0;
      chk("single_rom_addr", 32'(rom_addr), 32'h041);
      chk("single_rom_card", 32'(rom_card), 32'h5);
      @(negedge clk); chk("single_valid_t1", 32'(rgb_valid), 32'h0);
      tick();
      @(negedge clk);
      chk("single_valid_t2", 32'(rgb_valid), 32'h1);
      chk("single_rgb",      32'(rgb),       32'h101);
      tick();

      // Contention, two requesters held for 10 cycles
      do_reset();
      for (int i = 0; i < 12; i++) begin
         if (i < 10) begin
            req = 3'b011;
            addr[0] = 12'(i); addr[1] = 12'h800 + 12'(i);
            card_id[0] = 6'd1; card_id[1] = 6'd2;
         end else begin
            req = '0;
         end
         @(negedge clk);
         if (i < 10) chk("cont_gnt", 32'(gnt), 32'(pat[i]));
         if (i >= 2) chk("cont_valid", 32'(rgb_valid), 32'(pat[i-2]));
         tick();
      end

      // Wrap-around of the pointer with three requesters
      do_reset();
      req = 3'b010; addr[1] = 12'h123; card_id[1] = 6'd7;
      @(negedge clk); chk("wrap_first", 32'(gnt), 32'h2);
      tick(); req = 3'b011;
      @(negedge clk);
`ifdef ARB_BURST_EN
      chk("wrap_ptr2", 32'(gnt), 32'h2);
`else
      chk("wrap_ptr2", 32'(gnt), 32'h1);
`endif
      tick();
      @(negedge clk); chk("wrap_ptr1", 32'(gnt), 32'h2);
      tick(); req = '0;
      tick(); tick();
      req = 3'b100; addr[2] = 12'hFED; card_id[2] = 6'd52;
      @(negedge clk); chk("wrap_req2", 32'(gnt), 32'h4);
      tick(); req = 3'b111;
      @(negedge clk);
`ifdef ARB_BURST_EN
      chk("wrap_ptr0", 32'(gnt), 32'h4);
`else
      chk("wrap_ptr0", 32'(gnt), 32'h1);
`endif
      tick(); req = '0;
      tick(); tick();

      // Idle gap: req 1,0,1
      do_reset();
      req = 3'b001; addr[0] = 12'h0A5; card_id[0] = 6'd3;
      @(negedge clk); tick();
      req = '0;
      @(negedge clk); chk("idle_hold1", 32'(rom_addr), 32'h0A5);
      tick();
      req = 3'b001; addr[0] = 12'h3C7; card_id[0] = 6'd9;
      @(negedge clk);
      chk("idle_hold2",  32'(rom_addr),  32'h0A5);
      chk("idle_gnt2",   32'(gnt),       32'h1);
      chk("idle_valid2", 32'(rgb_valid), 32'h1);
      chk("idle_rgb2",   32'(rgb),       32'h065);
      tick(); req = '0;
      @(negedge clk);
      chk("idle_addr3",  32'(rom_addr),  32'h3C7);
      chk("idle_valid3", 32'(rgb_valid), 32'h0);
      tick();
      @(negedge clk);
      chk("idle_valid4", 32'(rgb_valid), 32'h1);
      chk("idle_rgb4",   32'(rgb),       32'h187);
      tick();
      @(negedge clk); chk("idle_valid5", 32'(rgb_valid), 32'h0);
      tick();

      // Reset one cycle after an accept
      req = 3'b001; addr[0] = 12'h155; card_id[0] = 6'd1;
      @(negedge clk); tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gnt",       32'(gnt),       32'h0);
      chk("mid_rst_rom_addr",  32'(rom_addr),  32'h0);
      chk("mid_rst_rom_card",  32'(rom_card),  32'h0);
      chk("mid_rst_rgb_valid", 32'(rgb_valid), 32'h0);
      chk("mid_rst_rgb",       32'(rgb),       32'h0);
      tick();
      req   = '0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("post_rst_valid", 32'(rgb_valid), 32'h0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
